// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Lets two execute-stage issue lanes share one combinational ALU. Each cycle
//   the arbiter grants at most one eligible lane, round-robin. It drives that
//   lane's operation onto the ALU and captures the ALU result into the lane's
//   one-entry response slot at the same clock edge. A lane's result is held
//   under a valid/ready handshake until the consumer takes it. A flush empties
//   both slots. A free-running counter records cycles in which both lanes
//   competed for the ALU.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           synchronous pipeline flush (clears both response slots)
//   reqN_*          lane N request: valid/ready handshake, aluop, operands, tag
//   respN_*         lane N response slot: valid/ready, registered result, tag
//   alu_aluop/reg1/reg2   drive to the shared ALU
//   alu_result      combinational result from the shared ALU
//   conflict_cnt    count of cycles with both lanes eligible
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int         TAG_W   = 4,
   parameter logic [7:0] ALU_NOP = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [7:0]       req0_aluop,
   input  logic [31:0]      req0_reg1,
   input  logic [31:0]      req0_reg2,
   input  logic [TAG_W-1:0] req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [7:0]       req1_aluop,
   input  logic [31:0]      req1_reg1,
   input  logic [31:0]      req1_reg2,
   input  logic [TAG_W-1:0] req1_tag,

   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [31:0]      resp0_result,
   output logic [TAG_W-1:0] resp0_tag,

   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [31:0]      resp1_result,
   output logic [TAG_W-1:0] resp1_tag,

   output logic [7:0]       alu_aluop,
   output logic [31:0]      alu_reg1,
   output logic [31:0]      alu_reg2,
   input  logic [31:0]      alu_result,

   output logic [31:0]      conflict_cnt
);

   // Lane-indexed views of the flat ports so per-lane logic can be generated.
   logic [1:0]       w_req_valid;
   logic [1:0]       w_resp_ready;
   logic [1:0]       w_resp_valid;
   logic [1:0]       w_elig;
   logic [1:0]       w_grant;
   logic [TAG_W-1:0] w_req_tag     [2];
   logic [31:0]      w_resp_result [2];
   logic [TAG_W-1:0] w_resp_tag    [2];

   logic             r_prio;
   logic [31:0]      r_conflict_cnt;

   assign w_req_valid  = {req1_valid, req0_valid};
   assign w_resp_ready = {resp1_ready, resp0_ready};
   assign w_req_tag[0] = req0_tag;
   assign w_req_tag[1] = req1_tag;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         localparam logic LANE = 1'(gi);

         logic             r_valid;
         logic [31:0]      r_result;
         logic [TAG_W-1:0] r_tag;

         // A full slot can accept a new request in the same cycle it drains.
         assign w_elig[gi] = w_req_valid[gi] && (!r_valid || w_resp_ready[gi]);

         // Favoured lane wins a tie; a lone eligible lane always wins. Reset
         // and flush suppress every grant so nothing upstream is told it was
         // accepted when the result would be discarded.
         assign w_grant[gi] = !rst && !flush && w_elig[gi] &&
                              (!w_elig[1-gi] || (r_prio == LANE));

         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid  <= 1'b0;
               r_result <= '0;
               r_tag    <= '0;
            end else if (flush) begin
               r_valid  <= 1'b0;
            end else if (w_grant[gi]) begin
               r_valid  <= 1'b1;
               r_result <= alu_result;
               r_tag    <= w_req_tag[gi];
            end else if (r_valid && w_resp_ready[gi]) begin
               // Data is left in place on release; only valid drops.
               r_valid  <= 1'b0;
            end
         end

         assign w_resp_valid[gi]  = r_valid;
         assign w_resp_result[gi] = r_result;
         assign w_resp_tag[gi]    = r_tag;
      end
   endgenerate

   // The last-granted lane becomes lowest priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio <= 1'b0;
      end else if (flush) begin
         r_prio <= 1'b0;
      end else if (w_grant[0]) begin
         r_prio <= 1'b1;
      end else if (w_grant[1]) begin
         r_prio <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_conflict_cnt <= '0;
      end else if (w_elig[0] && w_elig[1] && !flush) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   // ALU operand mux. When idle, drive the NOP code with zero operands so the
   // ALU settles to a known zero result instead of toggling on stale data.
   always_comb begin
      alu_aluop = ALU_NOP;
      alu_reg1  = '0;
      alu_reg2  = '0;
      if (w_grant[0]) begin
         alu_aluop = req0_aluop;
         alu_reg1  = req0_reg1;
         alu_reg2  = req0_reg2;
      end else if (w_grant[1]) begin
         alu_aluop = req1_aluop;
         alu_reg1  = req1_reg1;
         alu_reg2  = req1_reg2;
      end
   end

   assign req0_ready   = w_grant[0];
   assign req1_ready   = w_grant[1];
   assign resp0_valid  = w_resp_valid[0];
   assign resp1_valid  = w_resp_valid[1];
   assign resp0_result = w_resp_result[0];
   assign resp1_result = w_resp_result[1];
   assign resp0_tag    = w_resp_tag[0];
   assign resp1_tag    = w_resp_tag[1];
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational regular ALU instance between two issue requesters, lane 0 and lane 1, in the dual-issue execute stage.
- Arbitrates round-robin, drives the ALU operand and aluop inputs, and registers each result into a per-lane response slot. Latency is 1 cycle.
- Holds each lane's result with valid/ready handshakes until that lane consumes it.
- Supports pipeline flush and a conflict performance counter.

Parameters:
- TAG_W, 4, width of the per-request tag (ROB or pipeline id) returned with the result.
- ALU_NOP, 8'h00, aluop driven to the ALU when no lane is granted. This value must decode to the ALU default case, which yields result 0.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous pipeline flush
- req0_valid  in  1  lane 0 request valid
- req0_ready  out  1  lane 0 request accepted this cycle (combinational)
- req0_aluop  in  8  lane 0 ALU operation code (defines.vh encoding)
- req0_reg1  in  32  lane 0 operand 1
- req0_reg2  in  32  lane 0 operand 2
- req0_tag  in  TAG_W  lane 0 tag
- req1_valid, req1_ready, req1_aluop, req1_reg1, req1_reg2, req1_tag: same as lane 0, for lane 1
- resp0_valid  out  1  lane 0 result slot full
- resp0_ready  in  1  lane 0 consumer takes the result this cycle
- resp0_result  out  32  lane 0 registered result
- resp0_tag  out  TAG_W  lane 0 registered tag
- resp1_valid, resp1_ready, resp1_result, resp1_tag: same as lane 0, for lane 1
- alu_aluop  out  8  to the ALU aluop input
- alu_reg1  out  32  to the ALU reg1 input
- alu_reg2  out  32  to the ALU reg2 input
- alu_result  in  32  from the ALU result output (combinational, same cycle)
- conflict_cnt  out  32  cycles where both lanes were eligible and one was stalled

Behaviour:
- Reset (rst=1 at an edge):
  - resp*_valid=0, resp*_result=0, resp*_tag=0.
  - Priority pointer prio=0 (lane 0 favoured).
  - conflict_cnt=0.
  - Reset overrides flush and all requests. A reset mid-operation discards any in-flight grant.
- Eligibility: elig_i = req_i_valid && (!resp_i_valid || resp_i_ready). At most one outstanding result per lane; a slot freeing this cycle may be refilled in the same cycle.
- Grant (combinational, one-hot or none; no grant when flush=1):
  - Only one lane eligible: that lane is granted.
  - Both lanes eligible: lane prio is granted.
  - req_i_ready = grant_i. No combinational path from alu_result to any ready signal.
- ALU drive:
  - While lane g is granted: alu_aluop/reg1/reg2 = req_g fields.
  - With no grant: alu_aluop=ALU_NOP, alu_reg1=0, alu_reg2=0.
- Result capture, at the edge where grant_g=1:
  - resp_g_valid<=1, resp_g_result<=alu_result, resp_g_tag<=req_g_tag.
  - resp_g_valid rises 1 cycle after acceptance.
- Slot release: resp_i_valid && resp_i_ready && !grant_i → resp_i_valid<=0. On release, result and tag keep their old values; only valid drops.
- Simultaneous release and new grant on the same lane: the new result is loaded and valid stays 1.
- resp_i_ready while resp_i_valid=0 is ignored.
- Pointer update: after any grant to lane g, prio<=~g, so the last-granted lane becomes lowest priority. With no grant, prio is unchanged.
- conflict_cnt increments by 1 in any cycle with elig_0 && elig_1 && !flush. It wraps modulo 2^32.
- Flush (flush=1 at an edge, rst=0):
  - resp0_valid<=0, resp1_valid<=0; no grants that cycle; prio<=0.
  - conflict_cnt is retained.
  - resp_ready in the flush cycle has no effect beyond the clear.
- Outputs resp_* depend only on registers. ready depends on valid/ready inputs and internal state only.

Test Plan:
- Lane 0 only: req0 ADDW, reg1=5, reg2=7, tag=3 → req0_ready=1 same cycle, alu_aluop=`ALU_ADDW`; next cycle resp0_valid=1, result=12, tag=3; req1_ready stays 0.
- Both lanes valid for 4 cycles with resp*_ready=1, lane 0 SUBW(10,3), lane 1 XOR(0xF0,0x0F):
  - Grants alternate 0,1,0,1.
  - Results 7 and 0xFF on the respective lanes.
  - conflict_cnt=4.
- Backpressure: resp0_ready=0 after the first result, req0_valid held → req0_ready=0 and lane 1 is granted freely. Raising resp0_ready then grants lane 0 in that same cycle, and resp0_valid stays 1 with the new result.
- SLT with reg1=0xFFFFFFFF, reg2=1 on lane 1 → resp1_result=1. With no requests, alu_aluop=ALU_NOP and the operands are 0.
- Flush with both slots full and both requests valid → no ready that cycle; next cycle resp0_valid=resp1_valid=0, prio=0, conflict_cnt unchanged.
- Assert rst for 1 cycle mid-stream → all outputs 0 next cycle, conflict_cnt=0, and lane 0 wins the first subsequent conflict.
